instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 131 +++++++++++++
 tb/tb_instruction_decoder.sv | 102 ++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// instruction_decoder: registered 16-bit instruction decoder, one-cycle latency.
// Ports: clk, rst_n (sync active-low); instr[15:0] in (opcode = instr[15:11]);
//   out: cond_update, mem_wr, mem_rd, reg_wr, wSel/aSel/bSel[2:0], imm5, imm8, imm11.
// Optional: define INSTR_DECODER_ILLEGAL_EN to add registered output illegal,
//   set for reserved opcodes.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  output logic        cond_update,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        reg_wr,
  output logic [2:0]  wSel,
  output logic [2:0]  aSel,
  output logic [2:0]  bSel,
  output logic [4:0]  imm5,
  output logic [7:0]  imm8,
`ifdef INSTR_DECODER_ILLEGAL_EN
  output logic [10:0] imm11,
  output logic        illegal
`else
  output logic [10:0] imm11
`endif
);
  localparam logic [2:0] SP = 3'b111;
  localparam logic [2:0] LR = 3'b110;
  logic [4:0]  op;
  logic [2:0]  lo, mid, hi, top;
  logic        cond_update_d, mem_wr_d, mem_rd_d, reg_wr_d;
  logic        cond_update_q, mem_wr_q, mem_rd_q, reg_wr_q;
  logic [2:0]  wsel_d, asel_d, bsel_d, wsel_q, asel_q, bsel_q;
  logic [4:0]  imm5_q;
  logic [7:0]  imm8_q;
  logic [10:0] imm11_q;
  assign op  = instr[15:11];
  assign lo  = instr[2:0];
  assign mid = instr[5:3];
  assign hi  = instr[8:6];
  assign top = instr[10:8];
  always_comb begin
    cond_update_d = 1'b0;
    mem_wr_d      = 1'b0;
    mem_rd_d      = 1'b0;
    reg_wr_d      = 1'b0;
    wsel_d        = 3'b000;
    asel_d        = 3'b000;
    bsel_d        = 3'b000;
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        wsel_d = lo; asel_d = mid; reg_wr_d = 1'b1; cond_update_d = 1'b1;
      end
      5'b00011: begin
        wsel_d = lo; asel_d = mid; bsel_d = hi; reg_wr_d = 1'b1; cond_update_d = 1'b1;
      end
      5'b00100, 5'b00110, 5'b00111: begin
        wsel_d = top; asel_d = top; reg_wr_d = 1'b1; cond_update_d = 1'b1;
      end
      5'b00101: begin
        asel_d = top; cond_update_d = 1'b1;
      end
      5'b01000: begin
        wsel_d = lo; asel_d = lo; bsel_d = mid; reg_wr_d = 1'b1; cond_update_d = 1'b1;
      end
      5'b01001: begin
        asel_d = lo; bsel_d = mid; cond_update_d = 1'b1;
      end
      5'b01010, 5'b01100: begin
        asel_d = mid; bsel_d = lo; mem_wr_d = 1'b1;
      end
      5'b01011, 5'b01101: begin
        wsel_d = lo; asel_d = mid; mem_rd_d = 1'b1; reg_wr_d = 1'b1;
      end
      5'b01110: begin
        asel_d = SP; bsel_d = top; mem_wr_d = 1'b1;
      end
      5'b01111: begin
        wsel_d = top; asel_d = SP; mem_rd_d = 1'b1; reg_wr_d = 1'b1;
      end
      5'b11101: begin
        wsel_d = LR; reg_wr_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_update_q <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      wsel_q        <= 3'b000;
      asel_q        <= 3'b000;
      bsel_q        <= 3'b000;
      imm5_q        <= 5'd0;
      imm8_q        <= 8'd0;
      imm11_q       <= 11'd0;
    end else begin
      cond_update_q <= cond_update_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
      reg_wr_q      <= reg_wr_d;
      wsel_q        <= wsel_d;
      asel_q        <= asel_d;
      bsel_q        <= bsel_d;
      imm5_q        <= instr[10:6];
      imm8_q        <= instr[7:0];
      imm11_q       <= instr[10:0];
    end
  end
  assign cond_update = cond_update_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign reg_wr      = reg_wr_q;
  assign wSel        = wsel_q;
  assign aSel        = asel_q;
  assign bSel        = bsel_q;
  assign imm5        = imm5_q;
  assign imm8        = imm8_q;
  assign imm11       = imm11_q;
`ifdef INSTR_DECODER_ILLEGAL_EN
  logic illegal_d, illegal_q;
  // Reserved space: every opcode with the top bit set except B (11100) and BL (11101).
  assign illegal_d = op[4] && (op[4:1] != 4'b1110);
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`endif
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: directed self-checking bench for instruction_decoder.
module tb_instruction_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        cond_update, mem_wr, mem_rd, reg_wr;
  logic [2:0]  wSel, aSel, bSel;
  logic [4:0]  imm5;
  logic [7:0]  imm8;
  logic [10:0] imm11;
`ifdef INSTR_DECODER_ILLEGAL_EN
  logic        illegal;
`endif
  int errs = 0;
  int checks = 0;
  logic [3:0] st [32];
  logic [12:0] ctl;
  logic [23:0] imms;
  instruction_decoder dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .cond_update(cond_update), .mem_wr(mem_wr), .mem_rd(mem_rd), .reg_wr(reg_wr),
    .wSel(wSel), .aSel(aSel), .bSel(bSel),
    .imm5(imm5), .imm8(imm8),
`ifdef INSTR_DECODER_ILLEGAL_EN
    .imm11(imm11), .illegal(illegal)
`else
    .imm11(imm11)
`endif
  );
  always #5 clk = ~clk;
  // {cond_update, mem_wr, mem_rd, reg_wr, wSel, aSel, bSel}
  assign ctl  = {cond_update, mem_wr, mem_rd, reg_wr, wSel, aSel, bSel};
  assign imms = {imm5, imm8, imm11};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [15:0] i);
    @(negedge clk);
    rst_n = r;
    instr = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] v;
    logic [12:0] e;
    // strobes {cond_update, mem_wr, mem_rd, reg_wr} per opcode 0..31, hand-tabulated
    st = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1001, 4'b1001,
           4'b1001, 4'b1000, 4'b0100, 4'b0011, 4'b0100, 4'b0011, 4'b0100, 4'b0011,
           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    step(1'b0, 16'hFFFF);
    check("reset_ctl", {19'd0, ctl}, 32'd0);
    check("reset_imm", {8'd0, imms}, 32'd0);
`ifdef INSTR_DECODER_ILLEGAL_EN
    check("reset_illegal", {31'd0, illegal}, 32'd0);
`endif
    for (int op = 0; op < 32; op++) begin
      v = {op[4:0], 11'd0};
      step(1'b1, v);
      e = {st[op], (op == 29) ? 3'b110 : 3'b000,
           (op == 14 || op == 15) ? 3'b111 : 3'b000, 3'b000};
      check($sformatf("sweep_op%0d", op), {19'd0, ctl}, {19'd0, e});
      check($sformatf("excl_op%0d", op), {31'd0, mem_wr & (mem_rd | reg_wr)}, 32'd0);
`ifdef INSTR_DECODER_ILLEGAL_EN
      check($sformatf("illegal_op%0d", op), {31'd0, illegal},
            {31'd0, (op >= 16 && op != 28 && op != 29)});
`endif
    end
    step(1'b1, {5'b00011, 2'b00, 3'b010, 3'b101, 3'b110});
    check("addsub_ctl", {19'd0, ctl}, {19'd0, 13'b1_0_0_1_110_101_010});
    step(1'b1, 16'b01010_10101_011_100);
    check("str_ctl", {19'd0, ctl}, {19'd0, 13'b0_1_0_0_000_011_100});
    check("str_imm5", {27'd0, imm5}, 32'b10101);
    step(1'b1, 16'b11101_10101010101);
    check("bl_ctl", {19'd0, ctl}, {19'd0, 13'b0_0_0_1_110_000_000});
    check("bl_imm11", {21'd0, imm11}, 32'b10101010101);
    check("bl_imm8", {24'd0, imm8}, 32'b01010101);
    step(1'b1, 16'b00100_101_11001100);
    check("movimm_ctl", {19'd0, ctl}, {19'd0, 13'b1_0_0_1_101_101_000});
    check("movimm_imm8", {24'd0, imm8}, 32'hCC);
    step(1'b1, 16'b01111_011_00000101);
    check("ldrsp_ctl", {19'd0, ctl}, {19'd0, 13'b0_0_1_1_011_111_000});
    step(1'b0, 16'b01000_000_00_010_001);
    check("midrst_ctl", {19'd0, ctl}, 32'd0);
    check("midrst_imm", {8'd0, imms}, 32'd0);
    step(1'b1, 16'b01000_000_00_010_001);
    check("alu_ctl", {19'd0, ctl}, {19'd0, 13'b1_0_0_1_001_001_010});
`ifdef INSTR_DECODER_ILLEGAL_EN
    step(1'b1, {5'b10010, 11'd0});
    check("illegal_10010", {31'd0, illegal}, 32'd1);
    step(1'b1, {5'b00100, 11'd0});
    check("illegal_00100", {31'd0, illegal}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
